decode_stage_p: RTL
===================

// Module: decode_stage_p
// PURPOSE
//  Parametrised ID stage of the ARC MIPS pipeline: decodes opcode, reads the internal register file, sign-extends imm16.
//  Registers the result into the ID/EX pipeline register.
//  Adds valid/ready flow control, flush, downstream stall and load-use hazard bubbling.
//  Adds WB->ID write-through bypass and a saturating bubble counter.
//  Sits between fetch (IF/ID) and execute; WB write port comes back from the writeback stage.
// PARAMETERS
//  DATA_W      32  datapath width (registers, PC, sign-extended immediate)
//  REG_AW      5   register address width; register file depth = 2**REG_AW, reg 0 hardwired to zero
//  HAZARD_EN   1   1: load-use detection inserts bubbles; 0: detection disabled, o_ready = ~i_stall
//  CNT_W       16  width of bubble counter
// PORTS
//  i_clk            in   1       clock, all state on posedge
//  i_rst            in   1       synchronous active-high reset
//  i_valid          in   1       IF/ID holds a valid instruction
//  o_ready          out  1       ID accepts instruction this cycle (combinational)
//  i_flush          in   1       kill instruction in ID (taken branch)
//  i_stall          in   1       downstream stall: hold ID/EX register
//  i_addr_NextPC    in   DATA_W  PC+4 of instruction in ID
//  i_data_Instr     in   32      instruction word
//  i_con_RegWr      in   1       WB write enable
//  i_addr_WrReg     in   REG_AW  WB destination
//  i_data_WrData    in   DATA_W  WB data
//  o_valid          out  1       ID/EX register holds a valid instruction
//  o_con_ex_regdst, o_con_ex_alusrc, o_con_mem_branch, o_con_mem_memread, o_con_mem_memwrite,
//  o_con_wb_memtoreg, o_con_wb_regwrite   out 1 each   registered control bits
//  o_con_ex_aluop   out  2       registered ALU op class
//  o_illegal        out  1       registered: opcode not decoded
//  o_addr_NextPC    out  DATA_W  registered PC+4
//  o_data_rs/o_data_rt  out DATA_W  registered operands
//  o_data_SignExt   out  DATA_W  registered sign-extended imm16
//  o_addr_rs, o_addr_mux_0 (rt), o_addr_mux_1 (rd)  out REG_AW  registered register addresses
//  o_cnt_bubble     out  CNT_W   saturating count of hazard bubbles
// BEHAVIOUR
//  - Reset: all ID/EX outputs 0 (o_valid=0, controls 0, data 0); o_cnt_bubble=0; register file cleared to 0.
//  - Latency: 1 cycle. Instruction accepted at edge N appears on outputs after edge N.
//  - Decode: opcode [31:26]. R 000000: regdst,regwrite,aluop=10. lw 100011: alusrc,memread,memtoreg,regwrite,aluop=00.
//    sw 101011: alusrc,memwrite,aluop=00. beq 000100: branch,aluop=01. Others: all 0, illegal=1.
//  - Addresses: rs=[25:21], rt=[20:16], rd=[15:11], low REG_AW bits used.
//    SignExt = {{(DATA_W-16){imm[15]}},imm[15:0]}.
//  - Reads combinational. Reg 0 reads 0; writes to reg 0 ignored.
//    WB write to X with read of X in same cycle returns i_data_WrData (bypass).
//  - hazard = HAZARD_EN & i_valid & o_valid & o_con_mem_memread & (o_addr_mux_0!=0)
//    & (o_addr_mux_0==rs | (o_addr_mux_0==rt & opcode in {R,sw,beq})).
//  - o_ready = ~i_stall & ~hazard (i_flush does not affect o_ready).
//  - ID/EX update priority per edge:
//    1. i_rst
//    2. i_flush: load bubble (o_valid=0, all control 0, illegal 0), even when i_stall
//    3. i_stall: hold every output
//    4. hazard: load bubble; o_cnt_bubble+1, saturate at all-ones
//    5. otherwise: load decoded fields, o_valid=i_valid. If ~i_valid, controls forced 0.
//  - Register file write occurs on every edge with i_con_RegWr & ~i_rst, independent of stall/flush/hazard.
//  - Reset mid-operation: in-flight ID/EX contents discarded; no partial state survives.
//  - Bubble (valid=0) must never assert memwrite/regwrite/branch.
// STRUCTURE
//  - decode_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ).
//  - decode_pkg: aluop localparams (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10).
//  - decode_pkg: ctrl_t packed struct of the 9 control fields + illegal.
//  - Sub-module regfile_p #(DATA_W,REG_AW): 2 async read ports, 1 sync write port, sync reset, r0=0, write-through bypass.
//  - Decoder and sign-extend are inline combinational logic; ID/EX register and hazard logic live in the top.
// TESTING
//  1. Reset for 2 cycles.
//     -> all outputs 0, o_cnt_bubble=0.
//     Then R-type add $3,$1,$2 with r1=5,r2=7 preloaded via WB.
//     -> next cycle o_valid=1, rs=5, rt=7, regdst=1, aluop=10.
//  2. WB writes r4=0xDEADBEEF in the same cycle ID reads rs=4.
//     -> o_data_rs=0xDEADBEEF after edge.
//     WB to r0=0x1234, then read r0.
//     -> 0.
//  3. lw $5,0($1) then add $6,$5,$2.
//     -> o_ready=0 for 1 cycle, one bubble (o_valid=0, regwrite=0), o_cnt_bubble=1.
//     -> add issues the next cycle.
//     Repeat with HAZARD_EN=0.
//     -> no bubble.
//  4. i_stall=1 for 3 cycles with sw in ID/EX.
//     -> outputs constant, o_ready=0.
//     i_flush=1 during stall.
//     -> bubble loaded, memwrite=0.
//  5. imm16=0x8000 with DATA_W=32 -> SignExt=0xFFFF8000.
//     imm16=0x7FFF with DATA_W=64 -> SignExt=0x0000_0000_0000_7FFF.
//     Opcode 111111 -> illegal=1, all controls 0.
//  6. CNT_W=2, 5 load-use hazards -> o_cnt_bubble saturates at 3.
//     Assert i_rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage.
//   OP_*   : primary opcode values, instruction bits [31:26]
//   ALU_*  : ALU operation class handed to execute
//   ctrl_t : control bundle carried in the ID/EX register
//   decode_op() : opcode -> control bundle; unknown opcodes set illegal
package decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       branch;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic [1:0] aluop;
      logic       illegal;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
            c.aluop    = ALU_FUNCT;
         end
         OP_LW: begin
            c.alusrc   = 1'b1;
            c.memread  = 1'b1;
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
            c.aluop    = ALU_ADD;
         end
         OP_SW: begin
            c.alusrc   = 1'b1;
            c.memwrite = 1'b1;
            c.aluop    = ALU_ADD;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.aluop  = ALU_SUB;
         end
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/regfile_p.sv
// Register file for the ID stage.
//   i_clk, i_rst          : clock, synchronous active-high reset (clears all entries)
//   i_raddr_a/b, o_rdata_a/b : two combinational read ports
//   i_we, i_waddr, i_wdata   : one write port, committed on posedge
// Entry 0 always reads zero and ignores writes. A write to the entry being
// read in the same cycle is forwarded so ID sees the value WB is committing.
module regfile_p #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [REG_AW-1:0] i_raddr_a,
   input  logic [REG_AW-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata
);
   import decode_pkg::*;

   localparam int DEPTH = 1 << REG_AW;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic                         wr_ok;

   assign wr_ok = i_we && (i_waddr != '0);

   always_comb begin
      mem_d = mem_q;
      if (wr_ok) mem_d[i_waddr] = i_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) mem_q <= '0;
      else       mem_q <= mem_d;
   end

   assign o_rdata_a = (i_raddr_a == '0)                  ? '0      :
                      (wr_ok && (i_waddr == i_raddr_a))  ? i_wdata : mem_q[i_raddr_a];
   assign o_rdata_b = (i_raddr_b == '0)                  ? '0      :
                      (wr_ok && (i_waddr == i_raddr_b))  ? i_wdata : mem_q[i_raddr_b];

endmodule

// File: rtl/decode_stage_p.sv
// ID stage: decodes the instruction, reads operands, sign-extends imm16 and
// registers everything into the ID/EX register with valid/ready flow control.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_valid / o_ready         : IF/ID handshake (o_ready is combinational)
//   i_flush, i_stall          : kill ID contents / hold ID/EX
//   i_addr_NextPC, i_data_Instr : instruction in ID
//   i_con_RegWr, i_addr_WrReg, i_data_WrData : WB write port
//   o_valid, o_con_*, o_illegal, o_addr_*, o_data_* : ID/EX register
//   o_cnt_bubble              : saturating count of load-use bubbles
module decode_stage_p #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int HAZARD_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_flush,
   input  logic              i_stall,
   input  logic [DATA_W-1:0] i_addr_NextPC,
   input  logic [31:0]       i_data_Instr,
   input  logic              i_con_RegWr,
   input  logic [REG_AW-1:0] i_addr_WrReg,
   input  logic [DATA_W-1:0] i_data_WrData,
   output logic              o_valid,
   output logic              o_con_ex_regdst,
   output logic              o_con_ex_alusrc,
   output logic              o_con_mem_branch,
   output logic              o_con_mem_memread,
   output logic              o_con_mem_memwrite,
   output logic              o_con_wb_memtoreg,
   output logic              o_con_wb_regwrite,
   output logic [1:0]        o_con_ex_aluop,
   output logic              o_illegal,
   output logic [DATA_W-1:0] o_addr_NextPC,
   output logic [DATA_W-1:0] o_data_rs,
   output logic [DATA_W-1:0] o_data_rt,
   output logic [DATA_W-1:0] o_data_SignExt,
   output logic [REG_AW-1:0] o_addr_rs,
   output logic [REG_AW-1:0] o_addr_mux_0,
   output logic [REG_AW-1:0] o_addr_mux_1,
   output logic [CNT_W-1:0]  o_cnt_bubble
);
   import decode_pkg::*;

   localparam logic HZ_ON = (HAZARD_EN != 0);

   logic [5:0]        opcode;
   logic [REG_AW-1:0] rs_a, rt_a, rd_a;
   logic [DATA_W-1:0] rs_rd, rt_rd, sext;
   ctrl_t             ctrl_dec;
   logic              uses_rt, hazard;

   logic              valid_q, valid_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic [DATA_W-1:0] npc_q, npc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d;
   logic [DATA_W-1:0] sext_q, sext_d;
   logic [REG_AW-1:0] addr_rs_q, addr_rs_d, addr_rt_q, addr_rt_d, addr_rd_q, addr_rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   assign opcode   = i_data_Instr[31:26];
   assign rs_a     = i_data_Instr[21 +: REG_AW];
   assign rt_a     = i_data_Instr[16 +: REG_AW];
   assign rd_a     = i_data_Instr[11 +: REG_AW];
   assign sext     = {{(DATA_W-16){i_data_Instr[15]}}, i_data_Instr[15:0]};
   assign ctrl_dec = decode_op(opcode);

   regfile_p #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raddr_a (rs_a),
      .i_raddr_b (rt_a),
      .o_rdata_a (rs_rd),
      .o_rdata_b (rt_rd),
      .i_we      (i_con_RegWr),
      .i_waddr   (i_addr_WrReg),
      .i_wdata   (i_data_WrData)
   );

   // rt is only a true source for R-type, sw and beq; lw merely writes it.
   assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

   assign hazard = HZ_ON && i_valid && valid_q && ctrl_q.memread && (addr_rt_q != '0)
                   && ((addr_rt_q == rs_a) || ((addr_rt_q == rt_a) && uses_rt));

   assign o_ready = ~i_stall & ~hazard;

   always_comb begin
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      npc_d     = npc_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      sext_d    = sext_q;
      addr_rs_d = addr_rs_q;
      addr_rt_d = addr_rt_q;
      addr_rd_d = addr_rd_q;
      cnt_d     = cnt_q;
      // Bubbles clear only valid and control; stale data behind valid=0 is harmless.
      if (i_flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (i_stall) begin
         valid_d = valid_q;
      end else if (hazard) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
         valid_d   = i_valid;
         ctrl_d    = i_valid ? ctrl_dec : '0;
         npc_d     = i_addr_NextPC;
         rs_data_d = rs_rd;
         rt_data_d = rt_rd;
         sext_d    = sext;
         addr_rs_d = rs_a;
         addr_rt_d = rt_a;
         addr_rd_d = rd_a;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         npc_q     <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         sext_q    <= '0;
         addr_rs_q <= '0;
         addr_rt_q <= '0;
         addr_rd_q <= '0;
         cnt_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         npc_q     <= npc_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         sext_q    <= sext_d;
         addr_rs_q <= addr_rs_d;
         addr_rt_q <= addr_rt_d;
         addr_rd_q <= addr_rd_d;
         cnt_q     <= cnt_d;
      end
   end

   assign o_valid            = valid_q;
   assign o_con_ex_regdst    = ctrl_q.regdst;
   assign o_con_ex_alusrc    = ctrl_q.alusrc;
   assign o_con_mem_branch   = ctrl_q.branch;
   assign o_con_mem_memread  = ctrl_q.memread;
   assign o_con_mem_memwrite = ctrl_q.memwrite;
   assign o_con_wb_memtoreg  = ctrl_q.memtoreg;
   assign o_con_wb_regwrite  = ctrl_q.regwrite;
   assign o_con_ex_aluop     = ctrl_q.aluop;
   assign o_illegal          = ctrl_q.illegal;
   assign o_addr_NextPC      = npc_q;
   assign o_data_rs          = rs_data_q;
   assign o_data_rt          = rt_data_q;
   assign o_data_SignExt     = sext_q;
   assign o_addr_rs          = addr_rs_q;
   assign o_addr_mux_0       = addr_rt_q;
   assign o_addr_mux_1       = addr_rd_q;
   assign o_cnt_bubble       = cnt_q;

endmodule
